// File: rtl/mem_arbiter.sv
// Arbiter that shares a single memory port between instruction fetch and data access.
// Define MEM_ARBITER_FAIR_EN to alternate grants under contention; by default data always wins.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  input  logic        halt,
  output logic        active,
  output logic [2:0]  dbg_state_o
);

  // Handshake: a requester holds its request until its done pulse and drops it
  // the cycle after; the memory side accepts a strobe in any cycle where
  // mem_waitrequest is low, and strobes stay stable until then.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DATA   = 3'd2,
    S_RESP   = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  state_e      state_q;
  logic [31:0] mem_address_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_writedata_q;
  logic [3:0]  mem_byteenable_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        if_done_q;
  logic        d_done_q;
  logic        active_q;
  logic        data_pend;
  logic        grant_data_d;

  assign data_pend = d_read | d_write;

`ifdef MEM_ARBITER_FAIR_EN
  // 1 = data was granted last, 0 = fetch was granted last
  logic last_grant_q;
  assign grant_data_d = data_pend & (~if_req | ~last_grant_q);
`else
  assign grant_data_d = data_pend;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      mem_address_q    <= 32'h0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_writedata_q  <= 32'h0;
      mem_byteenable_q <= 4'h0;
      if_rdata_q       <= 32'h0;
      d_rdata_q        <= 32'h0;
      if_done_q        <= 1'b0;
      d_done_q         <= 1'b0;
      active_q         <= 1'b1;
`ifdef MEM_ARBITER_FAIR_EN
      last_grant_q     <= 1'b0;
`endif
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (halt) begin
            state_q  <= S_HALTED;
            active_q <= 1'b0;
          end else if (grant_data_d) begin
            state_q          <= S_DATA;
            mem_address_q    <= d_addr;
            mem_writedata_q  <= d_wdata;
            mem_byteenable_q <= d_byteenable;
            // A simultaneous read and write request is served as a write.
            mem_write_q      <= d_write;
            mem_read_q       <= ~d_write;
`ifdef MEM_ARBITER_FAIR_EN
            last_grant_q     <= 1'b1;
`endif
          end else if (if_req) begin
            state_q          <= S_FETCH;
            mem_address_q    <= if_addr;
            mem_writedata_q  <= 32'h0;
            mem_byteenable_q <= 4'hF;
            mem_read_q       <= 1'b1;
            mem_write_q      <= 1'b0;
`ifdef MEM_ARBITER_FAIR_EN
            last_grant_q     <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          if (!mem_waitrequest) begin
            if_rdata_q <= mem_readdata;
            mem_read_q <= 1'b0;
            if_done_q  <= 1'b1;
            state_q    <= S_RESP;
          end
        end
        S_DATA: begin
          if (!mem_waitrequest) begin
            if (mem_read_q) begin
              d_rdata_q <= mem_readdata;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            d_done_q    <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (halt) begin
            state_q  <= S_HALTED;
            active_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HALTED: begin
          state_q  <= S_HALTED;
          active_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_byteenable = mem_byteenable_q;
  assign if_rdata       = if_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign if_done        = if_done_q;
  assign d_done         = d_done_q;
  assign active         = active_q;
  assign dbg_state_o    = state_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-002 The block SHALL expose these instruction-fetch ports: if_req  in  1  fetch request; if_addr  in  32  fetch byte address; if_rdata  out  32  fetched word; if_done  out  1  one-cycle fetch completion pulse.
REQ-003 The block SHALL expose these data-access ports: d_read  in  1  load request; d_write  in  1  store request; d_addr  in  32  data address; d_wdata  in  32  store data; d_byteenable  in  4  store lanes; d_rdata  out  32  load data; d_done  out  1  one-cycle data completion pulse.
REQ-004 The block SHALL expose these memory ports: mem_address  out  32; mem_read  out  1; mem_write  out  1; mem_writedata  out  32; mem_byteenable  out  4; mem_readdata  in  32; mem_waitrequest  in  1  memory stall.
REQ-005 The block SHALL expose these status ports: halt  in  1  CPU halt request; active  out  1  high until the halted state is reached.

Function
REQ-006 The block SHALL arbitrate one unified memory port between fetch and data requesters using FSM states IDLE, FETCH, DATA, RESP and HALTED.
REQ-007 IDLE SHALL behave as follows: halt=1 -> HALTED; else a pending data request (d_read|d_write) -> DATA; else if_req -> FETCH; else stay in IDLE.
REQ-008 On entry to FETCH or DATA, the block SHALL latch address, wdata and byteenable; in DATA with d_read=d_write=1, the write SHALL win.
REQ-009 In FETCH or DATA, mem_read or mem_write SHALL be held high from registered outputs with stable address, data and byteenable until a cycle in which mem_waitrequest=0.
REQ-010 In the cycle where mem_waitrequest=0, the block SHALL capture mem_readdata into if_rdata or d_rdata (reads only) and go to RESP.
REQ-011 In RESP, the block SHALL drop mem strobes, pulse exactly one of if_done or d_done for one cycle, and then go to IDLE, or to HALTED if halt=1.
REQ-012 Minimum latency SHALL be 3 cycles from request sampled in IDLE to done, plus one cycle per waitrequest stall cycle.
REQ-013 Requesters SHALL hold their request signals until done and deassert them the cycle after done; deasserting a request mid-transaction SHALL NOT abort it.
REQ-014 if_rdata and d_rdata SHALL hold their last captured value until the next read of the same type completes.
REQ-015 A halt asserted during FETCH, DATA or RESP SHALL let the current transaction complete, including its done pulse, before the FSM enters HALTED.
REQ-016 HALTED SHALL be exited only by reset; in HALTED, active=0, no grants are issued, and all requests are ignored.
REQ-017 Only one memory transaction SHALL be outstanding at any time, and mem_read and mem_write SHALL never both be high.

Reset
REQ-018 Reset SHALL be asynchronous: the FSM goes to IDLE; mem_read, mem_write, if_done and d_done go to 0; mem_address, mem_writedata, if_rdata and d_rdata go to 0; mem_byteenable goes to 0; active goes to 1.
REQ-019 Reset asserted mid-transaction SHALL abort it immediately with no done pulse, and strobes SHALL fall in the same cycle as reset.
REQ-020 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge with reset low.

Configuration
REQ-021 The macro MEM_ARBITER_FAIR_EN SHALL select the arbitration policy.
REQ-022 With MEM_ARBITER_FAIR_EN defined, a last_grant register (reset value: fetch) SHALL be kept; when both requesters are pending in IDLE, the one not granted last SHALL win.
REQ-023 Without MEM_ARBITER_FAIR_EN, data SHALL always win over fetch, as per REQ-007, and no last_grant state SHALL exist.

Verification
REQ-024 Fetch, no stall: if_req=1 with if_addr=0x00000010, mem_readdata=0x8C220004, waitrequest=0 -> mem_read high 1 cycle at 0x10; if_done pulses on cycle 3; if_rdata=0x8C220004.
REQ-025 Store with stall: d_write=1, d_addr=0x100, d_wdata=0xDEADBEEF, be=0xF, waitrequest=1 for 2 cycles -> mem_write held 3 cycles with stable address and data; d_done on cycle 5; d_rdata unchanged.
REQ-026 Contention, both requesters asserted in IDLE for 4 consecutive transactions -> default build grants D,D,D,D; with MEM_ARBITER_FAIR_EN the build grants D,F,D,F.
REQ-027 Halt during a load (d_read at 0x200, 1 stall cycle, halt raised in DATA) -> d_done pulses, then HALTED, active=0, and a subsequent if_req produces no mem_read.
REQ-028 Reset in the stall cycle of a fetch -> mem_read=0 asynchronously, no if_done; after release, a fresh if_req at 0x4 completes normally in 3 cycles.
REQ-029 Simultaneous d_read=d_write=1 at 0x40 -> only mem_write is asserted and mem_read stays 0 for the whole transaction.
